// File: rtl/scan_rd_engine_if.sv
// scan_rd_engine_if: control, CCI-P c0 request/response and output stream bundle of scan_rd_engine.
// SCAN_RD_PERF_CNT_EN adds the perf_cycles/perf_stalls counter outputs.
interface scan_rd_engine_if #(parameter int CNT_W = 32);
    logic             start;
    logic [41:0]      base_addr;
    logic [CNT_W-1:0] num_lines;
    logic             busy;
    logic             done;
    logic             c0_req_valid;
    logic [41:0]      c0_req_addr;
    logic             c0_alm_full;
    logic             c0_rsp_valid;
    logic [511:0]     c0_rsp_data;
    logic             out_valid;
    logic             out_ready;
    logic [511:0]     out_data;
    logic             out_last;
`ifdef SCAN_RD_PERF_CNT_EN
    logic [CNT_W-1:0] perf_cycles;
    logic [CNT_W-1:0] perf_stalls;
    modport master (
        output start, base_addr, num_lines, c0_alm_full, c0_rsp_valid, c0_rsp_data, out_ready,
        input  busy, done, c0_req_valid, c0_req_addr, out_valid, out_data, out_last, perf_cycles, perf_stalls
    );
    modport slave (
        input  start, base_addr, num_lines, c0_alm_full, c0_rsp_valid, c0_rsp_data, out_ready,
        output busy, done, c0_req_valid, c0_req_addr, out_valid, out_data, out_last, perf_cycles, perf_stalls
    );
`else
    modport master (
        output start, base_addr, num_lines, c0_alm_full, c0_rsp_valid, c0_rsp_data, out_ready,
        input  busy, done, c0_req_valid, c0_req_addr, out_valid, out_data, out_last
    );
    modport slave (
        input  start, base_addr, num_lines, c0_alm_full, c0_rsp_valid, c0_rsp_data, out_ready,
        output busy, done, c0_req_valid, c0_req_addr, out_valid, out_data, out_last
    );
`endif
endinterface

// File: rtl/scan_rd_engine.sv
// scan_rd_engine: streams num_lines cache lines from base_addr via c0 reads into a credit-limited FIFO.
// SCAN_RD_PERF_CNT_EN adds busy-cycle and request-stall performance counters.
module scan_rd_engine #(
    parameter int FIFO_DEPTH = 64,
    parameter int CNT_W      = 32
) (
    input logic             clk,
    input logic             reset,
    scan_rd_engine_if.slave bus
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t           r_state;
    logic [41:0]      r_base;
    logic [CNT_W-1:0] r_num;
    logic [CNT_W-1:0] r_issued;
    logic [CNT_W-1:0] r_delivered;
    logic [CW-1:0]    r_in_flight;
    logic [CW-1:0]    r_count;
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [511:0]     r_mem [FIFO_DEPTH];
    logic             r_req_valid;
    logic [41:0]      r_req_addr;

    logic w_start, w_push, w_pop, w_want, w_credit, w_issue, w_out_valid, w_out_last;

    assign w_start     = bus.start && r_state == IDLE;
    assign w_push      = bus.c0_rsp_valid;
    assign w_out_valid = r_count != '0;
    assign w_out_last  = w_out_valid && r_delivered == r_num - 1'b1;
    assign w_pop       = w_out_valid && bus.out_ready;
    assign w_want      = r_state == RUN && r_issued != r_num;
    // Credits cover both lines in flight and lines already buffered, so the FIFO can never overflow.
    assign w_credit    = (r_in_flight + r_count) < CW'(FIFO_DEPTH);
    assign w_issue     = w_want && !bus.c0_alm_full && w_credit;

    assign bus.busy         = r_state != IDLE;
    assign bus.done         = r_state == DONE;
    assign bus.c0_req_valid = r_req_valid;
    assign bus.c0_req_addr  = r_req_addr;
    assign bus.out_valid    = w_out_valid;
    assign bus.out_data     = r_mem[r_rd_ptr];
    assign bus.out_last     = w_out_last;

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= bus.c0_rsp_data;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= IDLE;
            r_base      <= '0;
            r_num       <= '0;
            r_issued    <= '0;
            r_delivered <= '0;
            r_in_flight <= '0;
            r_count     <= '0;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_req_valid <= 1'b0;
            r_req_addr  <= '0;
        end else begin
            r_req_valid <= w_issue;
            r_in_flight <= r_in_flight + CW'(w_issue) - CW'(w_push);
            r_count     <= r_count + CW'(w_push) - CW'(w_pop);
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop) begin
                r_rd_ptr    <= r_rd_ptr + 1'b1;
                r_delivered <= r_delivered + 1'b1;
            end
            if (w_issue) begin
                r_req_addr <= r_base + 42'(r_issued);
                r_issued   <= r_issued + 1'b1;
            end
            case (r_state)
                IDLE: if (bus.start) begin
                    r_base      <= bus.base_addr;
                    r_num       <= bus.num_lines;
                    r_issued    <= '0;
                    r_delivered <= '0;
                    r_state     <= bus.num_lines == '0 ? DONE : RUN;
                end
                RUN:   if (w_issue && r_issued + 1'b1 == r_num) r_state <= DRAIN;
                DRAIN: if (w_pop && w_out_last) r_state <= DONE;
                DONE:  r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

`ifdef SCAN_RD_PERF_CNT_EN
    logic [CNT_W-1:0] r_perf_cycles;
    logic [CNT_W-1:0] r_perf_stalls;

    assign bus.perf_cycles = r_perf_cycles;
    assign bus.perf_stalls = r_perf_stalls;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_perf_cycles <= '0;
            r_perf_stalls <= '0;
        end else if (w_start) begin
            r_perf_cycles <= '0;
            r_perf_stalls <= '0;
        end else begin
            if (r_state != IDLE && !(&r_perf_cycles)) r_perf_cycles <= r_perf_cycles + 1'b1;
            if (w_want && !w_issue && !(&r_perf_stalls)) r_perf_stalls <= r_perf_stalls + 1'b1;
        end
    end
`endif

    a_no_overflow: assert property (@(posedge clk) disable iff (!reset)
        !(w_push && r_count == CW'(FIFO_DEPTH) && !w_pop));
endmodule

// File: tb/tb_scan_rd_engine.sv
// tb_scan_rd_engine: randomized scans against a memory/stream reference model of scan_rd_engine.
module tb_scan_rd_engine;
    localparam int DEPTH = 64;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    scan_rd_engine_if #(.CNT_W(32)) bus ();
    scan_rd_engine #(.FIFO_DEPTH(DEPTH), .CNT_W(32)) dut (.clk(clk), .reset(reset), .bus(bus));

    function automatic logic [511:0] line_of(input logic [41:0] a);
        return {8{a ^ 42'h155_5555_5555, a[21:0]}};
    endfunction

    task automatic idle_inputs();
        bus.start        = 1'b0;
        bus.base_addr    = '0;
        bus.num_lines    = '0;
        bus.c0_alm_full  = 1'b0;
        bus.c0_rsp_valid = 1'b0;
        bus.c0_rsp_data  = '0;
        bus.out_ready    = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        logic [46:0] got;
        got = {bus.busy, bus.done, bus.c0_req_valid, bus.c0_req_addr, bus.out_valid, bus.out_last};
        n_vec++;
        if (got !== 47'd0) begin
            n_err++;
            $display("FAIL %s outputs got=%h want=0", tag, got);
        end
`ifdef SCAN_RD_PERF_CNT_EN
        n_vec++;
        if (bus.perf_cycles !== 32'd0 || bus.perf_stalls !== 32'd0) begin
            n_err++;
            $display("FAIL %s perf got=%0d/%0d want=0/0", tag, bus.perf_cycles, bus.perf_stalls);
        end
`endif
    endtask

    // One scan: the model is a memory returning line_of(addr) in request order after lat cycles,
    // and a stream consumer expecting lines base..base+n-1.
    task automatic scan(input logic [41:0] base, input int n, input int lat, input int rdy_pct, input int hold,
                        input int alm_at, input int restart_at, input int abort_at, input bit consec, input int exp_stalls);
        logic [41:0] pq_addr[$];
        int pq_due[$];
        int reqs = 0, dlv = 0, cyc = 0, done_cnt = 0, done_cyc = -1, last_cyc = -1, first_req = -1, last_req = -1;
        bit fin = 0;
        @(posedge clk); #1;
        bus.start = 1'b1;
        bus.base_addr = base;
        bus.num_lines = n;
        while (!fin) begin
            @(posedge clk); #1;
            cyc++;
            bus.start = cyc == restart_at;
            if (cyc == restart_at) begin
                bus.base_addr = base ^ 42'h5A5;
                bus.num_lines = n + 7;
            end
            bus.c0_alm_full = alm_at >= 0 && cyc >= alm_at && cyc < alm_at + 10;
            if (cyc == abort_at) begin
                n_vec++;
                if (reqs != n || !bus.busy) begin
                    n_err++;
                    $display("FAIL abort_precond reqs=%0d busy=%b want reqs=%0d busy=1", reqs, bus.busy, n);
                end
                reset = 1'b0;
                #1;
                check_reset_outputs("reset_mid_drain");
                @(posedge clk); #1;
                idle_inputs();
                reset = 1'b1;
                @(posedge clk); #1;
                return;
            end
            if (bus.c0_req_valid) begin
                n_vec++;
                if (bus.c0_req_addr !== base + 42'(reqs) || reqs >= n || reqs + 1 - dlv > DEPTH) begin
                    n_err++;
                    $display("FAIL req_addr got=%h want=%h (req #%0d of %0d, outstanding %0d)",
                             bus.c0_req_addr, base + 42'(reqs), reqs, n, reqs + 1 - dlv);
                end
                if (alm_at >= 0 && cyc > alm_at && cyc <= alm_at + 10) begin
                    n_err++;
                    $display("FAIL alm_full_hold request at cycle %0d want none in %0d..%0d", cyc, alm_at + 1, alm_at + 10);
                end
                if (first_req < 0) first_req = cyc;
                last_req = cyc;
                pq_addr.push_back(bus.c0_req_addr);
                pq_due.push_back(cyc + lat);
                reqs++;
            end
            if (pq_due.size() > 0 && pq_due[0] <= cyc) begin
                bus.c0_rsp_valid = 1'b1;
                bus.c0_rsp_data  = line_of(pq_addr.pop_front());
                void'(pq_due.pop_front());
            end else begin
                bus.c0_rsp_valid = 1'b0;
            end
            if (hold > 0 && cyc == hold) begin
                n_vec++;
                if (reqs != (n < DEPTH ? n : DEPTH)) begin
                    n_err++;
                    $display("FAIL credit_stall reqs got=%0d want=%0d", reqs, n < DEPTH ? n : DEPTH);
                end
            end
            bus.out_ready = cyc > hold && $urandom_range(99) < rdy_pct;
            if (bus.out_valid && bus.out_ready) begin
                n_vec++;
                if (bus.out_data !== line_of(base + 42'(dlv)) || bus.out_last !== (dlv == n - 1)) begin
                    n_err++;
                    $display("FAIL out_line #%0d got last=%b data=%h want last=%b data=%h", dlv, bus.out_last,
                             bus.out_data[63:0], dlv == n - 1, line_of(base + 42'(dlv)) & 512'hFFFF_FFFF_FFFF_FFFF);
                end
                dlv++;
                if (dlv == n) last_cyc = cyc;
            end
            if (bus.done) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = cyc;
            end
            if (done_cyc >= 0 && cyc > done_cyc + 3) fin = 1;
            if (cyc > 5000) begin
                n_vec++;
                n_err++;
                $display("FAIL timeout reqs=%0d dlv=%0d want %0d done", reqs, dlv, n);
                fin = 1;
            end
        end
        bus.out_ready = 1'b0;
        n_vec++;
        if (reqs != n || dlv != n || done_cnt != 1 || bus.busy !== 1'b0) begin
            n_err++;
            $display("FAIL scan_end reqs=%0d dlv=%0d done_pulses=%0d busy=%b want %0d/%0d/1/0", reqs, dlv, done_cnt, bus.busy, n, n);
        end
        n_vec++;
        if (done_cyc != (n > 0 ? last_cyc + 1 : 1)) begin
            n_err++;
            $display("FAIL done_timing got=%0d want=%0d", done_cyc, n > 0 ? last_cyc + 1 : 1);
        end
        if (consec) begin
            n_vec++;
            if (last_req - first_req != n - 1) begin
                n_err++;
                $display("FAIL req_consecutive span got=%0d want=%0d", last_req - first_req, n - 1);
            end
        end
`ifdef SCAN_RD_PERF_CNT_EN
        n_vec++;
        if (bus.perf_cycles !== 32'(done_cyc)) begin
            n_err++;
            $display("FAIL perf_cycles got=%0d want=%0d", bus.perf_cycles, done_cyc);
        end
        if (exp_stalls >= 0) begin
            n_vec++;
            if (bus.perf_stalls !== 32'(exp_stalls)) begin
                n_err++;
                $display("FAIL perf_stalls got=%0d want=%0d", bus.perf_stalls, exp_stalls);
            end
        end
`endif
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        reset = 1'b1;
        @(posedge clk); #1;
        check_reset_outputs("after_reset");
    endtask

    task automatic test_basic();
        scan(42'h100, 4, 3, 100, 0, -1, -1, -1, 1, 0);
    endtask

    task automatic test_zero_lines();
        scan(42'h2000, 0, 3, 100, 0, -1, -1, -1, 0, 0);
    endtask

    task automatic test_credit_stall();
        scan(42'h4_0000, 200, 4, 100, 150, -1, -1, -1, 0, -1);
    endtask

    task automatic test_alm_full();
        scan(42'h1234, 40, 3, 100, 0, 5, -1, -1, 0, 10);
    endtask

    task automatic test_wrap();
        scan(42'h3FF_FFFF_FFFE, 4, 2, 100, 0, -1, -1, -1, 1, 0);
    endtask

    task automatic test_restart_ignored();
        scan(42'h777, 20, 5, 70, 0, -1, 4, -1, 0, -1);
    endtask

    task automatic test_reset_mid_drain();
        scan(42'h9000, 10, 3, 100, 60, -1, -1, 40, 0, -1);
        scan(42'hA000, 5, 2, 100, 0, -1, -1, -1, 1, 0);
    endtask

    task automatic test_random();
        for (int k = 0; k < 4; k++)
            scan({$urandom, $urandom} & 42'h3FF_FFFF_FFFF, $urandom_range(90, 1), $urandom_range(6, 1),
                 $urandom_range(100, 30), 0, -1, -1, -1, 0, -1);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero_lines();
        test_credit_stall();
        test_alm_full();
        test_wrap();
        test_restart_ignored();
        test_reset_mid_drain();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
